// File: rtl/an_encoder_seq.sv
// Sequential AN-code encoder: computes (A*N mod 2^W) ^ err_mask by shift-and-add,
// one data bit per cycle, with an overflow flag for A*N >= 2^W.
module an_encoder_seq #(
  parameter int A = 19,
  parameter int K = 4,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] data_in,
  input  logic [W-1:0] err_mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] code_out,
  output logic         ovf
);
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int SW = W + 1 + K;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [K-1:0]  d;
  logic [W-1:0]  m;
  logic [W:0]    acc;
  logic [CW-1:0] i;
  logic          ovf_q;
  logic [SW-1:0] addend, sum;
  logic          last, accept;

  assign last   = (i == CW'(K-1));
  assign accept = in_valid && in_ready;
  assign addend = SW'(A) << i;
  assign sum    = {{K{1'b0}}, acc} + (d[0] ? addend : '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE) && !rst;
    code_out  = '0;
    ovf       = 1'b0;
    if (out_valid) begin
      code_out = acc[W-1:0] ^ m;
      ovf      = ovf_q | acc[W];
    end
  end

  // Bits above W are folded into a sticky flag; bit W stays in ACC.
  always_ff @(posedge clk) begin
    if (rst) begin
      d     <= '0;
      m     <= '0;
      acc   <= '0;
      i     <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          d     <= data_in;
          m     <= err_mask;
          acc   <= '0;
          i     <= '0;
          ovf_q <= 1'b0;
        end
        CALC: begin
          acc   <= sum[W:0];
          ovf_q <= ovf_q | (|sum[SW-1:W+1]);
          d     <= d >> 1;
          i     <= i + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/an_encoder_seq.md
# an_encoder_seq

Sequential AN-code encoder. It accepts a K-bit data word N and produces the arithmetic codeword A·N through a shift-and-add multiply, one data bit per cycle. A per-word error mask can be XORed onto the codeword for BER experiments. It is the transmit side of the AN decoder; its output feeds the decoder directly or a channel model. The default configuration (A=19, K=4, W=9) matches the decoder's 9-bit codeword input and 4-bit data output.

## Interface
- A, 19, code constant; odd, 3 ≤ A < 2^W
- K, 4, data width in bits
- W, 9, codeword width in bits; the default holds the full A·(2^K−1)
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  data_in and err_mask are valid
- in_ready  output  1  encoder can accept a word
- data_in  input  K  data word N
- err_mask  input  W  bits XORed onto the codeword; 0 for a clean codeword
- out_valid  output  1  code_out and ovf are valid
- out_ready  input  1  downstream accepts the codeword
- code_out  output  W  (A·N mod 2^W) XOR err_mask
- ovf  output  1  A·N ≥ 2^W; the codeword is truncated

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE, clears the accumulator, the shift register, the bit counter, the mask register and the ovf register.
- in_ready = (state==IDLE) && !rst. out_valid = (state==DONE).
- IDLE: when in_valid && in_ready at an edge:
  - latch data_in into shift register D and err_mask into register M
  - clear accumulator ACC (W+1 bits) and counter i
  - go to CALC
- CALC, one step per cycle:
  - if D[0]=1, ACC ← ACC + (A << i), computed in W+1+K bits
  - any carry at or above bit W sets a sticky overflow flag
  - ACC keeps its low W bits plus bit W
  - D shifts right by 1; i increments
  - after the step with i = K−1, go to DONE
- DONE:
  - code_out = ACC[W−1:0] XOR M
  - ovf = sticky overflow OR ACC[W]
  - hold code_out and ovf stable until out_valid && out_ready, then go to IDLE
- code_out and ovf are 0 in IDLE and in CALC.
- in_valid while not in IDLE is ignored. The upstream must hold the word until in_ready.
- No early termination: CALC always takes K cycles, including N=0.
- The mask is never applied to the accumulator. ovf reflects A·N only, not the mask.

## Timing
- Reset: on the first edge with rst=1 the state becomes IDLE. in_ready, out_valid, code_out and ovf are all 0 while rst=1.
  - in_ready rises in the first cycle after rst falls.
- Acceptance at edge e0. CALC steps happen on edges e1..eK. out_valid is high from just after eK.
  - Latency: K cycles from acceptance to out_valid (4 in the default configuration).
- Output handshake at edge eD: out_valid drops and in_ready rises after eD.
  - Next acceptance is at eD+1 at the earliest.
  - Maximum throughput: one word per K+2 cycles.
- out_ready held at 0 stalls the encoder in DONE indefinitely, with outputs unchanged.
- rst=1 in any state, including mid-CALC and DONE with out_valid high:
  - the in-flight word is dropped with no output
  - state is IDLE on the next cycle
  - rst has priority over every handshake at the same edge
- in_valid and out_ready are never both effective at the same edge, because IDLE and DONE are exclusive.

## Test plan
- Defaults, N=11, mask=0 → out_valid 4 cycles after acceptance, code_out=209, ovf=0. Feed code_out to the decoder → Nc=11.
- Defaults, N=11, masks 2, 4, 8, 32, 256, 1 → code_out 211, 213, 217, 241, 465, 208. The decoder returns 11 for each.
- Defaults, N=0 → code_out=0 after 4 cycles. N=15 → code_out=285, ovf=0.
- Override W=8: N=15 → code_out=29, ovf=1. N=13 (247) → code_out=247, ovf=0.
- Backpressure: N=5, out_ready=0 for 10 cycles → code_out=95 stable and in_ready=0 for the whole stall. New data_in applied during CALC or DONE is ignored. After out_ready=1, the next word is accepted one cycle later.
- Reset mid-CALC (rst pulsed 2 cycles after acceptance) → out_valid never rises for that word, in_ready=1 after rst falls. The next word N=3 → code_out=57.
